// File: rtl/dmem_wait_unit.sv
// Word-addressed data memory that stalls the pipeline for WAIT_CYCLES per access.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_wait_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        stall
);

  localparam int IW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic          req;
  logic          mis_now;
  logic          we;
  logic [IW-1:0] widx;
  logic [31:0]   wd;
  logic          mis_set;
  logic          unused;

  assign idx = adr[IW+1:2];
  assign req = mem_read | mem_write;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_now = (adr[1:0] != 2'b00);
`else
  assign mis_now = 1'b0;
`endif

  assign unused = &{1'b0, adr[31:IW+2], adr[1:0], mis_set};

  // Storage is cleared by reset so software sees a known image after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wd;
    end
  end

  if (WAIT_CYCLES == 0) begin : g_comb
    assign stall   = 1'b0;
    assign rdata   = mis_now ? '0 : mem[idx];
    assign we      = mem_write & ~mis_now;
    assign widx    = idx;
    assign wd      = wdata;
    assign mis_set = req & mis_now;
  end else begin : g_fsm
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [IW-1:0] l_idx;
    logic [31:0]   l_wdata;
    logic          l_wr;
    logic          l_rd;
    logic          l_mis;
    logic [31:0]   rdata_q;
    logic          fin;
    logic          f_wr;
    logic          f_rd;
    logic          f_mis;
    logic [IW-1:0] f_idx;
    logic [31:0]   f_wdata;

    // The completing edge uses live inputs when N==1 (IDLE->DONE), latched ones otherwise.
    always_comb begin
      fin     = 1'b0;
      f_wr    = l_wr;
      f_rd    = l_rd;
      f_mis   = l_mis;
      f_idx   = l_idx;
      f_wdata = l_wdata;
      if (state == S_IDLE) begin
        fin     = req && (WAIT_CYCLES == 1);
        f_wr    = mem_write;
        f_rd    = mem_read;
        f_mis   = mis_now;
        f_idx   = idx;
        f_wdata = wdata;
      end else if (state == S_WAIT) begin
        fin = (cnt == 4'd1);
      end
    end

    assign stall   = ((state == S_IDLE) && req) || (state == S_WAIT);
    assign we      = fin & f_wr & ~f_mis;
    assign widx    = f_idx;
    assign wd      = f_wdata;
    assign mis_set = fin & f_mis;
    assign rdata   = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: if (req) begin
            state <= (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
            cnt   <= CNT_INIT;
          end
          S_WAIT: begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if ((state == S_IDLE) && req) begin
        l_idx   <= idx;
        l_wdata <= wdata;
        l_wr    <= mem_write;
        l_rd    <= mem_read;
        l_mis   <= mis_now;
      end
    end

    // With both strobes high this samples the pre-write word at the commit edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (fin && (f_rd || f_mis)) begin
        rdata_q <= f_mis ? '0 : mem[f_idx];
      end
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= mis_set;
  end
`endif

endmodule

// File: tb/tb_dmem_wait_unit.sv
// Directed bench for dmem_wait_unit with four instances (WAIT_CYCLES 0..3) on shared inputs.
module tb_dmem_wait_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [31:0] rdata0, rdata1, rdata2, rdata3;
  logic        stall0, stall1, stall2, stall3;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        mis0, mis1, mis2, mis3;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_wait_unit #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) d0 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .adr(adr), .wdata(wdata), .rdata(rdata0),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misalign(mis0),
`endif
    .stall(stall0));

  dmem_wait_unit #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) d1 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .adr(adr), .wdata(wdata), .rdata(rdata1),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misalign(mis1),
`endif
    .stall(stall1));

  dmem_wait_unit #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) d2 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .adr(adr), .wdata(wdata), .rdata(rdata2),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misalign(mis2),
`endif
    .stall(stall2));

  dmem_wait_unit #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) d3 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .adr(adr), .wdata(wdata), .rdata(rdata3),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misalign(mis3),
`endif
    .stall(stall3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    mem_read  = rd;
    mem_write = wr;
    adr       = a;
    wdata     = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    #1;
    chk("rst stall1", {31'b0, stall1}, 32'h0);
    chk("rst stall2", {31'b0, stall2}, 32'h0);
    chk("rst stall3", {31'b0, stall3}, 32'h0);
    chk("rst rdata1", rdata1, 32'h0);
    chk("rst rdata2", rdata2, 32'h0);
    chk("rst rdata3", rdata3, 32'h0);
    chk("rst rdata0", rdata0, 32'h0);
    rst = 1'b0;

    // N=2 write then read
    do_reset();
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF); #1;
    chk("A wr stall c0", {31'b0, stall2}, 32'h1);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("A wr stall c1", {31'b0, stall2}, 32'h1);
    tick(); #1;
    chk("A wr done stall", {31'b0, stall2}, 32'h0);
    tick(); drive(1'b1, 1'b0, 32'h10, 32'h0); #1;
    chk("A rd stall c0", {31'b0, stall2}, 32'h1);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("A rd stall c1", {31'b0, stall2}, 32'h1);
    tick(); #1;
    chk("A rd done stall", {31'b0, stall2}, 32'h0);
    chk("A rd data", rdata2, 32'hDEADBEEF);
    tick(); #1;
    chk("A rdata hold", rdata2, 32'hDEADBEEF);

    // N=0 combinational path
    do_reset();
    drive(1'b0, 1'b1, 32'h8, 32'h1234); #1;
    chk("B wr stall", {31'b0, stall0}, 32'h0);
    chk("B pre-write rdata", rdata0, 32'h0);
    tick(); drive(1'b1, 1'b0, 32'h8, 32'h0); #1;
    chk("B rd stall", {31'b0, stall0}, 32'h0);
    chk("B rd data", rdata0, 32'h1234);

    // N=1 simultaneous strobes
    do_reset();
    drive(1'b1, 1'b1, 32'h4, 32'h55); #1;
    chk("C both stall", {31'b0, stall1}, 32'h1);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("C done stall", {31'b0, stall1}, 32'h0);
    chk("C old data", rdata1, 32'h0);
    tick(); drive(1'b1, 1'b0, 32'h4, 32'h0); #1;
    chk("C rd stall", {31'b0, stall1}, 32'h1);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("C new data", rdata1, 32'h55);

    // Address wrap at 4 KiB
    do_reset();
    drive(1'b0, 1'b1, 32'h1000, 32'hA5);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    drive(1'b1, 1'b0, 32'h0, 32'h0); #1;
    chk("D wrap comb", rdata0, 32'hA5);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); #1;
    chk("D wrap stall", {31'b0, stall2}, 32'h0);
    chk("D wrap data", rdata2, 32'hA5);

    // N=3 reset during second stall cycle
    do_reset();
    drive(1'b0, 1'b1, 32'h20, 32'h77); #1;
    chk("E stall c0", {31'b0, stall3}, 32'h1);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("E stall c1", {31'b0, stall3}, 32'h1);
    rst = 1'b1; #1;
    chk("E stall drop", {31'b0, stall3}, 32'h0);
    tick(); rst = 1'b0;
    drive(1'b1, 1'b0, 32'h20, 32'h0); #1;
    chk("E rd stall c0", {31'b0, stall3}, 32'h1);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("E rd stall c1", {31'b0, stall3}, 32'h1);
    tick(); #1;
    chk("E rd stall c2", {31'b0, stall3}, 32'h1);
    tick(); #1;
    chk("E rd done stall", {31'b0, stall3}, 32'h0);
    chk("E discarded write", rdata3, 32'h0);

`ifdef DMEM_MISALIGN_TRAP_EN
    // Misaligned write is suppressed and flagged
    do_reset();
    drive(1'b0, 1'b1, 32'h22, 32'h99); #1;
    chk("F mis c0", {31'b0, mis2}, 32'h0);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("F mis c1", {31'b0, mis2}, 32'h0);
    tick(); #1;
    chk("F mis done", {31'b0, mis2}, 32'h1);
    chk("F done stall", {31'b0, stall2}, 32'h0);
    tick(); drive(1'b1, 1'b0, 32'h20, 32'h0); #1;
    chk("F mis clear", {31'b0, mis2}, 32'h0);
    chk("F comb rd", rdata0, 32'h0);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); #1;
    chk("F rd data", rdata2, 32'h0);
    chk("F mis quiet", {31'b0, mis2}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
